// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// riscv_mc_pkg
//   Shared types and constants for the multicycle RISC-V control unit:
//   the 4-bit state enumeration, the decoded opcodes, the ALU operation
//   classes and the ALU B-input selections.  Also holds two small state
//   classification helpers used by the FSM and the performance counters.
//
// Optional build macro used by the design that imports this package:
//   PERF_CNT_EN (performance counters in multicycle_control)
// ----------------------------------------------------------------------------
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_ERROR  = 4'd15
    } state_t;

    // Opcodes (inst[6:0]) understood by the sequencer
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    // ALU B-input select
    localparam logic [1:0] ALUB_REG  = 2'd0;
    localparam logic [1:0] ALUB_FOUR = 2'd1;
    localparam logic [1:0] ALUB_IMM  = 2'd2;

    // States that own the memory port and wait on mem_ready
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // Final state of an instruction: leaving it for FETCH retires the instruction
    function automatic logic is_retire_state(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
               (s == S_BRANCH) || (s == S_IWB);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
//   Bundle between the multicycle control FSM and the datapath.
//
//   Datapath -> control : opcode[6:0], zero, mem_ready
//   Control -> datapath : iord, memread, memwrite, irwrite, pcwrite,
//                         pcwritecond, pcsource, alusrca, alusrcb[1:0],
//                         aluop[1:0], regwrite, memtoreg, err, state_o[3:0]
//
//   Modports: master = control unit, slave = datapath side.
// ----------------------------------------------------------------------------
interface multicycle_control_if;
    import riscv_mc_pkg::*;

    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic       pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       memtoreg;
    logic       err;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output iord, memread, memwrite, irwrite, pcwrite, pcwritecond,
               pcsource, alusrca, alusrcb, aluop, regwrite, memtoreg,
               err, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  iord, memread, memwrite, irwrite, pcwrite, pcwritecond,
               pcsource, alusrca, alusrcb, aluop, regwrite, memtoreg,
               err, state_o
    );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
//   Wait-state counter for the memory-owning states of the control FSM.
//
//   Ports:
//     clk        in  rising-edge clock
//     rst        in  asynchronous active-low reset (count -> 0)
//     i_clr      in  clear the count (state change); wins over i_inc
//     i_inc      in  count one more wait cycle
//     o_timeout  out count has reached TIMEOUT_CYCLES
//
//   Parameters:
//     TIMEOUT_CYCLES  wait cycles tolerated (1..255)
//     TMR_W           counter width, 2^TMR_W > TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TMR_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_timeout
);

    localparam logic [TMR_W-1:0] LP_LIMIT = TMR_W'(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] r_count;

    // The FSM leaves the waiting state on the cycle the limit is seen, so
    // the count never needs to go past LP_LIMIT and cannot wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = (r_count == LP_LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Moore control FSM for a multicycle RISC-V datapath (R-type, beq, addi,
//   lw, sw) sharing one instruction/data memory port.  Memory states wait on
//   mem_ready; a wait longer than TIMEOUT_CYCLES sends the FSM to an absorbing
//   ERROR state that only reset leaves.
//
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   asynchronous active-low reset
//     ctrl_bus  master modport of multicycle_control_if
//                    (opcode/zero/mem_ready in, control strobes, err, state_o out)
//   With PERF_CNT_EN defined:
//     cycle_cnt    out 32  cycles spent outside ERROR since reset
//     instret_cnt  out 32  retired instructions since reset
//
//   Build macro: PERF_CNT_EN adds the two performance counters.
// ----------------------------------------------------------------------------
module multicycle_control
    import riscv_mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TMR_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    multicycle_control_if.master         ctrl_bus
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]                  cycle_cnt,
    output logic [31:0]                  instret_cnt
`endif
);

    state_t     r_state;
    state_t     w_next;
    logic       w_wait;
    logic       w_timeout;
    logic       w_state_chg;

    logic       w_iord;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_pcwritecond;
    logic       w_pcsource;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic       w_regwrite;
    logic       w_memtoreg;
    logic       w_err;

    // The zero flag is qualified in the datapath, not by the sequencer.
    logic       w_unused_zero;
    assign w_unused_zero = ctrl_bus.zero;

    // A cycle spent in a memory state without mem_ready is a wait cycle.
    assign w_wait      = is_mem_wait_state(r_state) && !ctrl_bus.mem_ready;
    assign w_state_chg = (w_next != r_state);

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_state_chg),
        .i_inc     (w_wait),
        .o_timeout (w_timeout)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.  In the memory states mem_ready is tested before
    // the timeout so a completion on the timeout cycle still advances.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (ctrl_bus.mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end
            end
            S_DECODE: begin
                case (ctrl_bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_IEXEC;
                    default:      w_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                // The instruction register is stable here; anything other
                // than lw/sw cannot reach this state, but is trapped anyway.
                case (ctrl_bus.opcode)
                    OP_LW:   w_next = S_MEMRD;
                    OP_SW:   w_next = S_MEMWR;
                    default: w_next = S_ERROR;
                endcase
            end
            S_MEMRD: begin
                if (ctrl_bus.mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end
            end
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR: begin
                if (ctrl_bus.mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end
            end
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_ERROR;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode.  Pure function of state, except the FETCH strobes
    // that load IR and PC only once the memory has delivered the word.
    // ------------------------------------------------------------------
    always_comb begin
        w_iord        = 1'b0;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_irwrite     = 1'b0;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_pcsource    = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = ALUB_REG;
        w_aluop       = ALUOP_ADD;
        w_regwrite    = 1'b0;
        w_memtoreg    = 1'b0;
        w_err         = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = ALUB_FOUR;
                w_irwrite = ctrl_bus.mem_ready;
                w_pcwrite = ctrl_bus.mem_ready;
            end
            S_DECODE: begin
                // PC + imm lands in ALUOut for a possible beq
                w_alusrcb = ALUB_IMM;
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = ALUB_IMM;
            end
            S_MEMRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            S_EXEC: begin
                w_alusrca = 1'b1;
                w_alusrcb = ALUB_REG;
                w_aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca     = 1'b1;
                w_alusrcb     = ALUB_REG;
                w_aluop       = ALUOP_SUB;
                w_pcwritecond = 1'b1;
                w_pcsource    = 1'b1;
            end
            S_IEXEC: begin
                w_alusrca = 1'b1;
                w_alusrcb = ALUB_IMM;
            end
            S_IWB: begin
                w_regwrite = 1'b1;
            end
            S_ERROR: begin
                w_err = 1'b1;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase

        // The state register clears asynchronously, but the strobes are also
        // killed straight from rst so an in-flight write never completes.
        if (!rst) begin
            w_memread     = 1'b0;
            w_memwrite    = 1'b0;
            w_irwrite     = 1'b0;
            w_pcwrite     = 1'b0;
            w_pcwritecond = 1'b0;
            w_regwrite    = 1'b0;
        end
    end

    assign ctrl_bus.iord        = w_iord;
    assign ctrl_bus.memread     = w_memread;
    assign ctrl_bus.memwrite    = w_memwrite;
    assign ctrl_bus.irwrite     = w_irwrite;
    assign ctrl_bus.pcwrite     = w_pcwrite;
    assign ctrl_bus.pcwritecond = w_pcwritecond;
    assign ctrl_bus.pcsource    = w_pcsource;
    assign ctrl_bus.alusrca     = w_alusrca;
    assign ctrl_bus.alusrcb     = w_alusrcb;
    assign ctrl_bus.aluop       = w_aluop;
    assign ctrl_bus.regwrite    = w_regwrite;
    assign ctrl_bus.memtoreg    = w_memtoreg;
    assign ctrl_bus.err         = w_err;
    assign ctrl_bus.state_o     = r_state;

`ifdef PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap modulo 2^32)
    // ------------------------------------------------------------------
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != S_ERROR) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (is_retire_state(r_state) && (w_next == S_FETCH)) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//   Randomised and directed stimulus for multicycle_control.  A reference
//   model describes each instruction as the list of states it walks through
//   and tracks wait cycles, retirement and error at that level; a compare
//   process checks every DUT output against it on each falling clock edge.
//   Directed sequences pin the model with hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int TO = 15;

    localparam logic [6:0] C_R    = 7'b0110011;
    localparam logic [6:0] C_BEQ  = 7'b1100011;
    localparam logic [6:0] C_ADDI = 7'b0010011;
    localparam logic [6:0] C_LW   = 7'b0000011;
    localparam logic [6:0] C_SW   = 7'b0100011;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic       pcsource;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regwrite;
        logic       memtoreg;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    multicycle_control #(
        .TIMEOUT_CYCLES (TO),
        .TMR_W          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_bus    (bus)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // State walk of one instruction, -1 past its end.
    function automatic int phase_state(input logic [6:0] op, input int ph);
        int seq[6];
        int n;
        case (op)
            C_R:     begin seq = '{0, 1, 6, 7, 0, 0};  n = 4; end
            C_BEQ:   begin seq = '{0, 1, 8, 0, 0, 0};  n = 3; end
            C_ADDI:  begin seq = '{0, 1, 9, 10, 0, 0}; n = 4; end
            C_LW:    begin seq = '{0, 1, 2, 3, 4, 0};  n = 5; end
            C_SW:    begin seq = '{0, 1, 2, 5, 0, 0};  n = 4; end
            default: begin seq = '{0, 1, 15, 0, 0, 0}; n = 3; end
        endcase
        return (ph < n) ? seq[ph] : -1;
    endfunction

    function automatic ctl_t spec_ctl(input int st, input logic mr, input logic rstn);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.memread = 1; c.alusrcb = 2'd1; c.irwrite = mr; c.pcwrite = mr; end
            1:  c.alusrcb = 2'd2;
            2:  begin c.alusrca = 1; c.alusrcb = 2'd2; end
            3:  begin c.memread = 1; c.iord = 1; end
            4:  begin c.regwrite = 1; c.memtoreg = 1; end
            5:  begin c.memwrite = 1; c.iord = 1; end
            6:  begin c.alusrca = 1; c.aluop = 2'd2; end
            7:  c.regwrite = 1;
            8:  begin c.alusrca = 1; c.aluop = 2'd1; c.pcwritecond = 1; c.pcsource = 1; end
            9:  begin c.alusrca = 1; c.alusrcb = 2'd2; end
            10: c.regwrite = 1;
            default: ;
        endcase
        if (!rstn) begin
            c.memread = 0; c.memwrite = 0; c.irwrite = 0;
            c.pcwrite = 0; c.pcwritecond = 0; c.regwrite = 0;
        end
        return c;
    endfunction

    logic [6:0]  op_src;
    logic [6:0]  m_op;
    int          m_ph = 0;
    bit          m_err = 0;
    int          m_wait = 0;
    int unsigned m_cyc = 0;
    int unsigned m_ret = 0;
    int          m_cur;
    int          m_nxt;
    bit          chk_en = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_op   = op_src;
            m_ph   = 0;
            m_err  = 0;
            m_wait = 0;
            m_cyc  = 0;
            m_ret  = 0;
        end else if (!m_err) begin
            m_cyc++;
            m_cur = phase_state(m_op, m_ph);
            if ((m_cur == 0 || m_cur == 3 || m_cur == 5) && !bus.mem_ready) begin
                if (m_wait == TO) begin
                    m_err  = 1;
                    m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
                m_ph++;
                m_nxt = phase_state(m_op, m_ph);
                if (m_nxt < 0) begin
                    m_ret++;
                    m_op = op_src;
                    m_ph = 0;
                end else if (m_nxt == 15) begin
                    m_err = 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int   e_st;
    ctl_t e_ctl;
    ctl_t a_ctl;

    always @(negedge clk) begin
        if (chk_en) begin
            e_st  = m_err ? 15 : phase_state(m_op, m_ph);
            e_ctl = spec_ctl(e_st, bus.mem_ready, rst);
            a_ctl = {bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.pcwrite,
                     bus.pcwritecond, bus.pcsource, bus.alusrca, bus.alusrcb,
                     bus.aluop, bus.regwrite, bus.memtoreg};
            check("state_o", bus.state_o, e_st);
            check("err", bus.err, m_err);
            check("ctl_word", a_ctl, e_ctl);
`ifdef PERF_CNT_EN
            check("cycle_cnt", cycle_cnt, m_cyc);
            check("instret_cnt", instret_cnt, m_ret);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [3:0] lg_st[64];
    logic       lg_rw[64];
    logic       lg_mw[64];
    logic       lg_mtr[64];
    logic       lg_pwc[64];
    logic       lg_ps[64];
    int         lg_n = 0;

    // Called at posedge+2; drives one cycle of inputs and logs the outputs.
    task automatic cyc(input logic mr, input logic z);
        bus.mem_ready = mr;
        bus.opcode    = m_op;
        bus.zero      = z;
        @(negedge clk);
        lg_st[lg_n]  = bus.state_o;
        lg_rw[lg_n]  = bus.regwrite;
        lg_mw[lg_n]  = bus.memwrite;
        lg_mtr[lg_n] = bus.memtoreg;
        lg_pwc[lg_n] = bus.pcwritecond;
        lg_ps[lg_n]  = bus.pcsource;
        if (lg_n < 63) lg_n++;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [6:0] op);
        op_src        = op;
        bus.mem_ready = 1'b0;
        rst           = 1'b0;
        chk_en        = 1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_state", bus.state_o, 0);
        check("rst_err", bus.err, 0);
        check("rst_memread", bus.memread, 0);
        rst        = 1'b1;
        bus.opcode = m_op;
        lg_n       = 0;
    endtask

    function automatic logic [6:0] pick_op();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0) return 7'($urandom);
        case (r % 5)
            0:       return C_R;
            1:       return C_BEQ;
            2:       return C_ADDI;
            3:       return C_LW;
            default: return C_SW;
        endcase
    endfunction

    int   exp_addi[5] = '{0, 1, 9, 10, 0};
    logic exp_addi_rw[5] = '{0, 0, 0, 1, 0};
    int   exp_lw[8]   = '{0, 1, 2, 3, 3, 3, 4, 0};
    logic lw_mr[8]    = '{1, 1, 1, 0, 0, 1, 1, 1};
    int   exp_beq[7]  = '{0, 1, 8, 0, 1, 8, 0};
    int   exp_ill[4]  = '{0, 1, 15, 15};
    int   stall_left;
    logic mr_r;
    int   pulses;

    initial begin
        bus.mem_ready = 1'b0;
        bus.opcode    = 7'd0;
        bus.zero      = 1'b0;
        op_src        = C_ADDI;
        @(posedge clk);
        #2;

        // addi with memory always ready
        do_reset(C_ADDI);
        repeat (5) cyc(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("addi_state", lg_st[i], exp_addi[i]);
            check("addi_regwrite", lg_rw[i], exp_addi_rw[i]);
        end

        // lw with two wait cycles in MEMRD
        do_reset(C_LW);
        for (int i = 0; i < 8; i++) cyc(lw_mr[i], 1'b0);
        for (int i = 0; i < 8; i++) check("lw_state", lg_st[i], exp_lw[i]);
        check("lw_memtoreg", lg_mtr[6], 1);

        // beq taken then not taken: strobes identical
        do_reset(C_BEQ);
        for (int i = 0; i < 7; i++) cyc(1'b1, (i < 3) ? 1'b1 : 1'b0);
        for (int i = 0; i < 7; i++) check("beq_state", lg_st[i], exp_beq[i]);
        check("beq_pwc_z1", lg_pwc[2], 1);
        check("beq_psrc_z1", lg_ps[2], 1);
        check("beq_pwc_z0", lg_pwc[5], 1);
        check("beq_psrc_z0", lg_ps[5], 1);

        // FETCH timeout: ERROR after the 16th wait cycle, sticky
        do_reset(C_R);
        repeat (17) cyc(1'b0, 1'b0);
        check("to_state16", lg_st[15], 0);
        check("to_state17", lg_st[16], 15);
        repeat (3) cyc(1'b1, 1'b0);
        check("to_err_sticky", bus.err, 1);
        check("to_state_sticky", bus.state_o, 15);
        do_reset(C_R);

        // mem_ready on the timeout cycle wins
        repeat (15) cyc(1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0);
        check("tie_state", lg_st[16], 1);

        // illegal opcode
        do_reset(7'b1111111);
        pulses = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("ill_state", lg_st[i], exp_ill[i]);
            pulses += int'(lg_rw[i]) + int'(lg_mw[i]);
        end
        check("ill_no_strobe", pulses, 0);

        // async reset in MEMWR drops memwrite within the cycle
        do_reset(C_SW);
        repeat (3) cyc(1'b0 | 1'b1, 1'b0);
        check("sw_in_memwr", bus.state_o, 5);
        check("sw_memwrite_hi", bus.memwrite, 1);
        rst = 1'b0;
        #1;
        check("sw_memwrite_drop", bus.memwrite, 0);
        check("sw_state_rst", bus.state_o, 0);
        @(posedge clk);
        #2;
        do_reset(C_ADDI);

`ifdef PERF_CNT_EN
        // addi, sw, lw back to back
        op_src = C_SW;
        repeat (4) cyc(1'b1, 1'b0);
        op_src = C_LW;
        repeat (9) cyc(1'b1, 1'b0);
        check("perf_cycles", cycle_cnt, 13);
        check("perf_instret", instret_cnt, 3);
        do_reset(C_R);
`endif

        // randomised run
        stall_left = 0;
        do_reset(pick_op());
        for (int i = 0; i < 4000; i++) begin
            op_src = pick_op();
            if (stall_left == 0 && $urandom_range(0, 99) == 0) stall_left = $urandom_range(8, 20);
            if (stall_left > 0) begin
                mr_r = 1'b0;
                stall_left--;
            end else begin
                mr_r = ($urandom_range(0, 9) < 7);
            end
            if (m_err && $urandom_range(0, 3) == 0) begin
                do_reset(pick_op());
            end else if ($urandom_range(0, 299) == 0) begin
                do_reset(pick_op());
            end else begin
                cyc(mr_r, 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences a multicycle RISC-V datapath built from the existing fetch/decode/execute/memory/writeback stages.
- One unified instruction/data memory port is shared; instruction fetch and load/store are time-multiplexed over it.
- Supports variable-latency memory through a mem_ready handshake, with a wait-state timeout.
- Decodes opcodes R-type (0110011), beq (1100011), addi (0010011), lw (0000011) and sw (0100011).

Parameters:
- TIMEOUT_CYCLES, 15: maximum wait cycles tolerated in a memory state before entering ERROR; legal range 1..255.
- TMR_W, 8: width of the wait-state counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  7  inst[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  load the instruction register.
- pcwrite  out  1  unconditional PC write.
- pcwritecond  out  1  PC write qualified by zero (beq).
- pcsource  out  1  PC source: 0 = ALU (PC+4), 1 = ALUOut (branch target).
- alusrca  out  1  ALU A input: 0 = PC, 1 = rs1 register.
- alusrcb  out  2  ALU B input: 0 = rs2, 1 = constant 4, 2 = ImmGen.
- aluop  out  2  ALU operation class: 0 = add, 1 = sub, 2 = funct-decoded.
- regwrite  out  1  register bank write enable.
- memtoreg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- err  out  1  sticky error flag.
- state_o  out  4  current state, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, ERROR=15.
- Reset (rst low, asynchronous): state=FETCH, wait counter=0, err=0. While rst is low, every write strobe (irwrite, pcwrite, pcwritecond, regwrite, memwrite) and memread is forced to 0 combinationally. All other outputs take their FETCH values.
- Outputs are a pure decode of state, except that irwrite and pcwrite in FETCH are additionally gated by mem_ready.
- FETCH:
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=1, aluop=0, pcsource=0.
  - irwrite = pcwrite = mem_ready.
  - Advance to DECODE when mem_ready=1; otherwise hold.
- DECODE:
  - Outputs: alusrca=0, alusrcb=2, aluop=0 (precomputes the branch target into ALUOut).
  - Next state by opcode: lw/sw -> MEMADR; R-type -> EXEC; beq -> BRANCH; addi -> IEXEC; any other opcode -> ERROR.
- MEMADR: alusrca=1, alusrcb=2, aluop=0. Next: MEMRD if the opcode is lw, MEMWR if sw.
- MEMRD: memread=1, iord=1. Wait for mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1. Next -> FETCH.
- MEMWR: memwrite=1, iord=1. Wait for mem_ready, then -> FETCH.
- EXEC: alusrca=1, alusrcb=0, aluop=2. Next -> RWB.
- RWB: regwrite=1, memtoreg=0. Next -> FETCH.
- BRANCH: alusrca=1, alusrcb=0, aluop=1, pcwritecond=1, pcsource=1. Next -> FETCH.
- IEXEC: alusrca=1, alusrcb=2, aluop=0. Next -> IWB.
- IWB: regwrite=1, memtoreg=0. Next -> FETCH.
- ERROR: all strobes 0, err=1. ERROR is absorbing; only reset exits it.
- Instruction latencies with mem_ready tied high: R-type, addi and sw take 4 cycles; lw takes 5; beq takes 3.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle the FSM is in FETCH, MEMRD or MEMWR with mem_ready=0.
  - When the counter equals TIMEOUT_CYCLES and mem_ready is still 0, next state is ERROR.
  - If mem_ready=1 arrives on the same cycle as the timeout, mem_ready wins and the FSM advances normally.
- mem_ready sampled outside FETCH, MEMRD and MEMWR is ignored.
- A reset assertion mid-transaction drops memwrite and memread immediately, with no completion cycle.

Optional Feature:
- Macro PERF_CNT_EN.
- When defined:
  - Adds 32-bit outputs cycle_cnt and instret_cnt, both reset to 0.
  - cycle_cnt increments every cycle outside ERROR.
  - instret_cnt increments on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH or IWB.
  - Both counters wrap modulo 2^32.
- When not defined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package riscv_mc_pkg contains:
  - the state enum (4-bit);
  - opcode localparams OP_R, OP_BEQ, OP_ADDI, OP_LW, OP_SW;
  - ALUOP_ADD/SUB/FUNCT;
  - ALUB_REG/FOUR/IMM.
- One sub-module, mem_wait_timer: counter with clear, increment and a timeout flag, parameterised by TIMEOUT_CYCLES and TMR_W.

Test Plan:
- addi (opcode 0010011), mem_ready=1 -> state sequence 0,1,9,10,0; regwrite high only in state 10; total 4 cycles.
- lw (0000011), mem_ready low for 2 cycles in MEMRD -> MEMRD held for 3 cycles, memtoreg=1 in MEMWB, total 7 cycles.
- beq with zero=1 -> pcwritecond=1 and pcsource=1 in BRANCH; with zero=0 the same strobes are asserted (qualification happens in the datapath); back to FETCH after 3 cycles.
- mem_ready held at 0 in FETCH with TIMEOUT_CYCLES=15 -> ERROR entered after the 16th wait cycle, err=1 and sticky; rst pulse -> state 0, err=0.
- Illegal opcode 1111111 in DECODE -> ERROR with no regwrite/memwrite pulse; asynchronous rst low during MEMWR -> memwrite falls within the same cycle.
- With PERF_CNT_EN defined, execute the sequence addi, sw, lw -> instret_cnt=3, cycle_cnt=13.
